// File: rtl/riscv_core_div_seq_if.sv
// Divider handshake bundle: issue operands/op, flush, and the result return path.
// slave = divider side, master = pipeline side driving operands and taking results.
interface riscv_core_div_seq_if #(
  parameter int XLEN = 32
);
  logic            i_div_flush;
  logic            i_div_valid;
  logic            o_div_ready;
  logic [XLEN-1:0] i_div_srcA;
  logic [XLEN-1:0] i_div_srcB;
  logic [1:0]      i_div_control;
  logic            i_div_isword;
  logic            o_div_valid;
  logic            i_div_ready;
  logic [XLEN-1:0] o_div_result;
  logic            o_div_busy;

  modport slave (
    input  i_div_flush, i_div_valid, i_div_srcA, i_div_srcB,
    input  i_div_control, i_div_isword, i_div_ready,
    output o_div_ready, o_div_valid, o_div_result, o_div_busy
  );

  modport master (
    output i_div_flush, i_div_valid, i_div_srcA, i_div_srcB,
    output i_div_control, i_div_isword, i_div_ready,
    input  o_div_ready, o_div_valid, o_div_result, o_div_busy
  );
endinterface

// File: rtl/riscv_core_div_seq.sv
// Radix-2 restoring divider (DIV/DIVU/REM/REMU and *W), one quotient bit per clock.
// Ports: i_clk, i_rst (sync, active-high), div (slave modport of the handshake bundle).
module riscv_core_div_seq #(
  parameter int XLEN    = 32,
  parameter bit WORD_EN = 1'b0
) (
  input logic                 i_clk,
  input logic                 i_rst,
  riscv_core_div_seq_if.slave div
);
  localparam int H  = XLEN / 2;
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN:0]   r_q, r_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            valid_q, valid_d;
  logic            rem_q, rem_d;
  logic            word_q, word_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;

  function automatic logic [XLEN-1:0] wfix(input logic w,
                                           input logic [XLEN-1:0] v);
    return w ? {{H{v[H-1]}}, v[H-1:0]} : v;
  endfunction

  logic            is_word, sgn, is_rem;
  logic            a_s, b_s, dz, ovf;
  logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs, min_v, sp_res;

  assign is_word = WORD_EN & div.i_div_isword;
  assign sgn     = ~div.i_div_control[0];
  assign is_rem  = div.i_div_control[1];

  always_comb begin
    a_ext = div.i_div_srcA;
    b_ext = div.i_div_srcB;
    min_v = {1'b1, {(XLEN-1){1'b0}}};
    if (is_word) begin
      a_ext = {{H{sgn & div.i_div_srcA[H-1]}}, div.i_div_srcA[H-1:0]};
      b_ext = {{H{sgn & div.i_div_srcB[H-1]}}, div.i_div_srcB[H-1:0]};
      min_v = {{(H+1){1'b1}}, {(H-1){1'b0}}};
    end
  end

  assign a_s   = sgn & a_ext[XLEN-1];
  assign b_s   = sgn & b_ext[XLEN-1];
  assign a_abs = a_s ? -a_ext : a_ext;
  assign b_abs = b_s ? -b_ext : b_ext;
  assign dz    = (b_ext == '0);
  assign ovf   = sgn & (a_ext == min_v) & (b_ext == '1);

  // divide-by-zero wins over overflow
  always_comb begin
    if (dz) sp_res = is_rem ? a_ext : '1;
    else    sp_res = is_rem ? '0 : a_ext;
  end

  // one restoring step; quotient bits enter a_q from the bottom
  logic [XLEN:0]   r_sh, r_nx;
  logic [XLEN-1:0] a_nx, q_fx, r_fx;
  logic            ge;

  assign r_sh = {r_q[XLEN-1:0], a_q[XLEN-1]};
  assign ge   = (r_sh >= {1'b0, b_q});
  assign r_nx = ge ? (r_sh - {1'b0, b_q}) : r_sh;
  assign a_nx = {a_q[XLEN-2:0], ge};
  assign q_fx = negq_q ? -a_nx : a_nx;
  assign r_fx = negr_q ? -r_nx[XLEN-1:0] : r_nx[XLEN-1:0];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    valid_d = valid_q;
    rem_d   = rem_q;
    word_d  = word_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    if (div.i_div_flush) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (div.i_div_valid) begin
          rem_d  = is_rem;
          word_d = is_word;
          negq_d = a_s ^ b_s;
          negr_d = a_s;
          if (dz | ovf) begin
            res_d   = wfix(is_word, sp_res);
            valid_d = 1'b1;
            state_d = DONE;
          end else begin
            // word dividend is pre-aligned so its msb sits at bit XLEN-1
            a_d     = is_word ? (a_abs << H) : a_abs;
            b_d     = b_abs;
            r_d     = '0;
            cnt_d   = is_word ? CW'(H-1) : CW'(XLEN-1);
            state_d = CALC;
          end
        end
        CALC: begin
          a_d   = a_nx;
          r_d   = r_nx;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == '0) begin
            res_d   = wfix(word_q, rem_q ? r_fx : q_fx);
            valid_d = 1'b1;
            state_d = DONE;
          end
        end
        DONE: if (div.i_div_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      res_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      rem_q   <= 1'b0;
      word_q  <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      res_q   <= res_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      word_q  <= word_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  assign div.o_div_ready  = (state_q == IDLE);
  assign div.o_div_busy   = (state_q != IDLE);
  assign div.o_div_valid  = valid_q;
  assign div.o_div_result = res_q;
endmodule
